// File: rtl/cpu_pkg.sv
// Shared fetch/control definitions: fetch FSM states, instruction field bounds,
// default reset PC and the opcode values the control unit decodes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_LOAD  = 6'd0;
  localparam logic [5:0] OP_STORE = 6'd1;
  localparam logic [5:0] OP_RTYPE = 6'd10;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats fall-through.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic [IMM_W-1:0]  branch_imm_i,
  input  logic [JIDX_W-1:0] jump_idx_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;

  // Word offset sign-extended to byte offset; the add wraps modulo 2^ADDR_W.
  assign br_off  = {{(ADDR_W-IMM_W-2){branch_imm_i[IMM_W-1]}}, branch_imm_i, 2'b00};
  assign br_tgt  = pc_plus4_i + br_off;
  assign jmp_tgt = {pc_plus4_i[ADDR_W-1:JIDX_W+2], jump_idx_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i)                next_pc_o = jmp_tgt;
    else if (branch_i && zero_i) next_pc_o = br_tgt;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake and holds the
// instruction for the control unit until the datapath commits it.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              commit,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  input  logic [15:0]       branch_imm,
  input  logic [25:0]       jump_idx
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4_i   (pc_plus4),
    .jump_i       (jump),
    .branch_i     (branch),
    .zero_i       (zero),
    .branch_imm_i (branch_imm),
    .jump_idx_i   (jump_idx),
    .next_pc_o    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // imem_req depends only on state_q, so there is no ack->req combinational path.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (commit) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[OPC_HI:OPC_LO];

endmodule
